cordic_rotator: RTL

//  Iterative fixed-point CORDIC engine in rotation mode. Computes cos/sin of a signed angle.

---
 rtl/cordic_rotator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC engine that computes cos/sin of a signed Q2.14 angle within +/-pi/2.
// It performs one micro-rotation per clock; results are Q.14, sign-extended to 32 bits and held between requests.
module cordic_rotator #(
    parameter int ITERATIONS = 14,
    parameter int DATA_W     = 16,
    parameter int FRAC_BITS  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] angle,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cos_out,
    output logic [31:0]       sin_out
);

    localparam int REG_W = DATA_W + 2;

    localparam logic signed [REG_W-1:0]  K_INIT    = REG_W'(9949);
    localparam logic signed [DATA_W-1:0] ANGLE_MAX = DATA_W'(25736);
    localparam logic signed [DATA_W-1:0] ANGLE_MIN = -ANGLE_MAX;
    localparam logic [3:0]               LAST_ITER = 4'(ITERATIONS - 1);

    // The ROM and the constants above are scaled for a 14-bit fraction.
    if (ITERATIONS < 8 || ITERATIONS > 16 || FRAC_BITS != 14 || DATA_W < 16) begin : g_param_check
        $error("cordic_rotator: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        FINISH
    } state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] angle_s;
    logic                     in_range;
    logic [3:0]               iter;
    logic signed [REG_W-1:0]  x, y, z;
    logic signed [REG_W-1:0]  x_next, y_next, z_next;
    logic signed [REG_W-1:0]  x_shr, y_shr, atan_i;
    logic                     rot_pos;

    function automatic logic signed [REG_W-1:0] atan_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    return REG_W'(12868);
            4'd1:    return REG_W'(7596);
            4'd2:    return REG_W'(4014);
            4'd3:    return REG_W'(2037);
            4'd4:    return REG_W'(1023);
            4'd5:    return REG_W'(512);
            4'd6:    return REG_W'(256);
            4'd7:    return REG_W'(128);
            4'd8:    return REG_W'(64);
            4'd9:    return REG_W'(32);
            4'd10:   return REG_W'(16);
            4'd11:   return REG_W'(8);
            4'd12:   return REG_W'(4);
            4'd13:   return REG_W'(2);
            4'd14:   return REG_W'(1);
            default: return REG_W'(0);
        endcase
    endfunction

    assign angle_s  = angle;
    assign in_range = (angle_s >= ANGLE_MIN) && (angle_s <= ANGLE_MAX);
    assign busy     = (state == ROTATE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave a latch behind.
        state_next = state;
        case (state)
            IDLE:    if (start && in_range) state_next = ROTATE;
            ROTATE:  if (iter == LAST_ITER) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One micro-rotation, steered by the sign of the residual angle.
    always_comb begin
        x_shr   = x >>> iter;
        y_shr   = y >>> iter;
        atan_i  = atan_rom(iter);
        rot_pos = ~z[REG_W-1];
        if (rot_pos) begin
            x_next = x - y_shr;
            y_next = y + x_shr;
            z_next = z - atan_i;
        end else begin
            x_next = x + y_shr;
            y_next = y - x_shr;
            z_next = z + atan_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            iter    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (in_range) begin
                            x    <= K_INIT;
                            y    <= '0;
                            z    <= REG_W'(angle_s);
                            iter <= '0;
                        end else begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            cos_out <= '0;
                            sin_out <= '0;
                        end
                    end
                end
                ROTATE: begin
                    x    <= x_next;
                    y    <= y_next;
                    z    <= z_next;
                    iter <= iter + 4'd1;
                end
                FINISH: begin
                    cos_out <= 32'(x);
                    sin_out <= 32'(y);
                    err     <= 1'b0;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
